// File: rtl/regfile_writeback_queue_if.sv
// Writeback queue bus: request side (InValid/InReady/InAddress/InValue),
// register-file side (ReadReq/ReadAddress in; mode/WriteAddress/WriteValue out),
// forwarding results (FwdHit/FwdValue) and occupancy status (Count/Empty).
// master: producer/register-file side driving requests; slave: the queue itself.
interface regfile_writeback_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic              InValid;
  logic              InReady;
  logic [4:0]        InAddress;
  logic [31:0]       InValue;
  logic              ReadReq;
  logic [4:0]        ReadAddress;
  logic              mode;
  logic [4:0]        WriteAddress;
  logic [31:0]       WriteValue;
  logic              FwdHit;
  logic [31:0]       FwdValue;
  logic [CountW-1:0] Count;
  logic              Empty;

  modport master (
    output InValid, InAddress, InValue, ReadReq, ReadAddress,
    input  InReady, mode, WriteAddress, WriteValue, FwdHit, FwdValue, Count, Empty
  );

  modport slave (
    input  InValid, InAddress, InValue, ReadReq, ReadAddress,
    output InReady, mode, WriteAddress, WriteValue, FwdHit, FwdValue, Count, Empty
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// Register-file writeback queue: a circular FIFO of DEPTH {address, value}
// entries that drains one entry per cycle into the register file whenever the
// read port is not needed, and forwards the youngest pending value for the
// address currently being read.
// Ports:
//   clk   - single clock, rising edge
//   rst_n - asynchronous active-low reset, clears all state and entries
//   bus   - slave modport: push handshake, register-file write port,
//           forwarding lookup and occupancy status
module regfile_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  regfile_writeback_queue_if.slave bus
);
  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CountW = $clog2(DEPTH) + 1;

  logic [PtrW-1:0]   headQ;
  logic [PtrW-1:0]   tailQ;
  logic [CountW-1:0] countQ;
  logic [4:0]        addrQ  [DEPTH];
  logic [31:0]       valueQ [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (countQ == CountW'(DEPTH));
  assign empty = (countQ == '0);
  // Acceptance depends only on registered occupancy, never on a same-cycle pop.
  assign push  = bus.InValid && !full;
  assign pop   = !empty && !bus.ReadReq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addrQ[i]  <= '0;
        valueQ[i] <= '0;
      end
    end else begin
      if (push) begin
        addrQ[tailQ]  <= bus.InAddress;
        valueQ[tailQ] <= bus.InValue;
        tailQ         <= tailQ + PtrW'(1);
      end
      if (pop) begin
        headQ <= headQ + PtrW'(1);
      end
      countQ <= countQ + CountW'(push) - CountW'(pop);
    end
  end

  // Walk entries oldest to youngest so the last match wins; the head entry is
  // included even while it is being popped.
  logic            fwdHit;
  logic [31:0]     fwdValue;
  logic [PtrW-1:0] idx;

  always_comb begin
    fwdHit   = 1'b0;
    fwdValue = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = headQ + PtrW'(i);
      if ((CountW'(i) < countQ) && (addrQ[idx] == bus.ReadAddress)) begin
        fwdHit   = 1'b1;
        fwdValue = valueQ[idx];
      end
    end
  end

  assign bus.InReady      = !full;
  assign bus.mode         = pop;
  assign bus.WriteAddress = pop ? addrQ[headQ]  : '0;
  assign bus.WriteValue   = pop ? valueQ[headQ] : '0;
  assign bus.FwdHit       = fwdHit;
  assign bus.FwdValue     = fwdValue;
  assign bus.Count        = countQ;
  assign bus.Empty        = empty;
endmodule
